// File: rtl/id_if.sv
// id_if: bundle between the IF stage register / WB stage / hazard unit on one
// side and the decode stage on the other.
//   master : drives the fetched instruction, PC+4, flags, stall and write-back
//            port; receives decoded control, operands and source indices.
//   slave  : the decode stage itself (id_stage).
interface id_if;
  // towards decode
  logic [31:0] instruction;
  logic [31:0] pc_in;
  logic [3:0]  status;       // {N,Z,C,V}
  logic        hazard;
  logic        wb_wb_en;
  logic [3:0]  wb_dest;
  logic [31:0] wb_value;
  // from decode
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic        b;
  logic        s;
  logic        imm;
  logic [3:0]  exe_cmd;
  logic [31:0] pc;
  logic [31:0] value_rn;
  logic [31:0] value_rm;
  logic [11:0] shift_operand;
  logic [23:0] imm_signed_24;
  logic [3:0]  dest;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic        two_src;

  modport master (
    output instruction, pc_in, status, hazard, wb_wb_en, wb_dest, wb_value,
    input  wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd, pc, value_rn,
           value_rm, shift_operand, imm_signed_24, dest, src1, src2, two_src
  );

  modport slave (
    input  instruction, pc_in, status, hazard, wb_wb_en, wb_dest, wb_value,
    output wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd, pc, value_rn,
           value_rm, shift_operand, imm_signed_24, dest, src1, src2, two_src
  );
endinterface

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the five-stage ARM pipeline.
// Holds R0..R14, decodes the fetched instruction into EXE/MEM/WB control,
// evaluates the condition field against NZCV and reads both operands.
// Ports:
//   clk  - pipeline clock; the register file is written on the falling edge
//   rst  - asynchronous active-high reset; loads R[i] = i
//   bus  - id_if.slave; instruction/pc/flags/hazard/write-back in,
//          decoded control, operands and hazard-unit source indices out
module id_stage (
  input logic   clk,
  input logic   rst,
  id_if.slave   bus
);

  // Register file plus a 16th read slot that maps index 15 to pc_in.
  logic [15:0][31:0] rd_view;

  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_rf
      logic [31:0] reg_q;
      logic [31:0] reg_d;

      // A write to index 15 never matches any entry, so it falls away here.
      always_comb begin
        reg_d = reg_q;
        if (bus.wb_wb_en && (bus.wb_dest == 4'(gi)))
          reg_d = bus.wb_value;
      end

      // Falling-edge write gives write-before-read within the same cycle.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) reg_q <= 32'(gi);
        else     reg_q <= reg_d;
      end

      assign rd_view[gi] = reg_q;
    end
  endgenerate

  assign rd_view[15] = bus.pc_in;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic       n_f, z_f, c_f, v_f;

  assign cond   = bus.instruction[31:28];
  assign mode   = bus.instruction[27:26];
  assign i_bit  = bus.instruction[25];
  assign opcode = bus.instruction[24:21];
  assign s_bit  = bus.instruction[20];
  assign {n_f, z_f, c_f, v_f} = bus.status;

  logic       cond_ok;
  logic       wb_en_raw, mem_r_en_raw, mem_w_en_raw, b_raw, s_raw;
  logic [3:0] exe_cmd_raw;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = (n_f == v_f);
      4'b1011: cond_ok = (n_f != v_f);
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  always_comb begin
    wb_en_raw    = 1'b0;
    mem_r_en_raw = 1'b0;
    mem_w_en_raw = 1'b0;
    b_raw        = 1'b0;
    s_raw        = 1'b0;
    exe_cmd_raw  = 4'b0000;
    case (mode)
      2'b00: begin
        s_raw = s_bit;
        case (opcode)
          4'b1101: begin exe_cmd_raw = 4'b0001; wb_en_raw = 1'b1; end // MOV
          4'b1111: begin exe_cmd_raw = 4'b1001; wb_en_raw = 1'b1; end // MVN
          4'b0100: begin exe_cmd_raw = 4'b0010; wb_en_raw = 1'b1; end // ADD
          4'b0101: begin exe_cmd_raw = 4'b0011; wb_en_raw = 1'b1; end // ADC
          4'b0010: begin exe_cmd_raw = 4'b0100; wb_en_raw = 1'b1; end // SUB
          4'b0110: begin exe_cmd_raw = 4'b0101; wb_en_raw = 1'b1; end // SBC
          4'b0000: begin exe_cmd_raw = 4'b0110; wb_en_raw = 1'b1; end // AND
          4'b1100: begin exe_cmd_raw = 4'b0111; wb_en_raw = 1'b1; end // ORR
          4'b0001: begin exe_cmd_raw = 4'b1000; wb_en_raw = 1'b1; end // EOR
          4'b1010: exe_cmd_raw = 4'b0100;                             // CMP
          4'b1000: exe_cmd_raw = 4'b0110;                             // TST
          default: exe_cmd_raw = 4'b0000;
        endcase
      end
      2'b01: begin
        exe_cmd_raw = 4'b0010;   // address = Rn + offset
        if (s_bit) begin
          mem_r_en_raw = 1'b1;   // LDR
          wb_en_raw    = 1'b1;
        end else begin
          mem_w_en_raw = 1'b1;   // STR
        end
      end
      2'b10:   b_raw = 1'b1;
      default: ;
    endcase
  end

  // Only side-effecting control is squashed; sources stay visible to the
  // hazard unit even while stalled.
  logic squash;
  assign squash = bus.hazard | ~cond_ok;

  assign bus.wb_en    = wb_en_raw    & ~squash;
  assign bus.mem_r_en = mem_r_en_raw & ~squash;
  assign bus.mem_w_en = mem_w_en_raw & ~squash;
  assign bus.b        = b_raw        & ~squash;
  assign bus.s        = s_raw        & ~squash;
  assign bus.imm      = i_bit;
  assign bus.exe_cmd  = exe_cmd_raw;

  // A store reads Rd as the data operand.
  assign bus.src1    = bus.instruction[19:16];
  assign bus.src2    = mem_w_en_raw ? bus.instruction[15:12] : bus.instruction[3:0];
  assign bus.two_src = ~i_bit | mem_w_en_raw;

  assign bus.value_rn      = rd_view[bus.src1];
  assign bus.value_rm      = rd_view[bus.src2];
  assign bus.pc            = bus.pc_in;
  assign bus.shift_operand = bus.instruction[11:0];
  assign bus.imm_signed_24 = bus.instruction[23:0];
  assign bus.dest          = bus.instruction[15:12];

endmodule

// File: tb/tb_id_stage.sv
module tb_id_stage;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  id_if bus ();

  id_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;   // posedge at 5,15,..; negedge at 10,20,..

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic after_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic after_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.instruction = 32'h0000_0000;
    bus.pc_in       = 32'h0000_0100;
    bus.status      = 4'b0000;
    bus.hazard      = 1'b0;
    bus.wb_wb_en    = 1'b0;
    bus.wb_dest     = 4'd0;
    bus.wb_value    = 32'h0;

    // Reset state: instruction 0 is AND EQ, squashed since Z=0
    #2;
    check("rst_wb_en",   32'(bus.wb_en), 32'd0);
    check("rst_exe_cmd", 32'(bus.exe_cmd), 32'd6);
    check("rst_rn",      bus.value_rn, 32'd0);
    #1 rst = 1'b0;
    $display("step reset released");

    // ADD R1,R2,R3
    after_pos();
    bus.instruction = 32'hE082_1003;
    #1;
    check("add_rn",      bus.value_rn, 32'd2);
    check("add_rm",      bus.value_rm, 32'd3);
    check("add_exe_cmd", 32'(bus.exe_cmd), 32'h2);
    check("add_wb_en",   32'(bus.wb_en), 32'd1);
    check("add_dest",    32'(bus.dest), 32'd1);
    check("add_two_src", 32'(bus.two_src), 32'd1);
    check("add_pc",      bus.pc, 32'h100);
    $display("step ADD R1,R2,R3 checked");

    // WB write R5, visible after negedge of the same cycle
    after_pos();
    bus.instruction = 32'hE085_100E;   // ADD R1,R5,R14
    bus.wb_wb_en    = 1'b1;
    bus.wb_dest     = 4'd5;
    bus.wb_value    = 32'hDEAD_BEEF;
    #1;
    check("wb_pre_rn", bus.value_rn, 32'd5);
    after_neg();
    check("wb_post_rn", bus.value_rn, 32'hDEAD_BEEF);
    $display("step WB R5 checked");

    // write to index 15 ignored
    after_pos();
    bus.wb_dest  = 4'd15;
    bus.wb_value = 32'h1234_5678;
    after_neg();
    check("wb15_r5",  bus.value_rn, 32'hDEAD_BEEF);
    check("wb15_r14", bus.value_rm, 32'd14);
    bus.wb_wb_en = 1'b0;
    bus.instruction = 32'hE08F_1003;   // ADD R1,PC,R3
    #1;
    check("rd15_pc", bus.value_rn, 32'h100);
    $display("step WB index 15 checked");

    // BEQ
    after_pos();
    bus.instruction = 32'h0A00_0010;
    bus.status      = 4'b0000;
    #1;
    check("beq_nt_b", 32'(bus.b), 32'd0);
    bus.status = 4'b0100;
    #1;
    check("beq_t_b",   32'(bus.b), 32'd1);
    check("beq_imm24", 32'(bus.imm_signed_24), 32'h10);
    // LT: N!=V taken, N==V not taken; cond 1111 never
    bus.instruction = 32'hBA00_0000;
    bus.status      = 4'b1000;
    #1;
    check("blt_t_b", 32'(bus.b), 32'd1);
    bus.status = 4'b1001;
    #1;
    check("blt_nt_b", 32'(bus.b), 32'd0);
    bus.instruction = 32'hFA00_0000;
    bus.status      = 4'b0100;
    #1;
    check("bnv_b", 32'(bus.b), 32'd0);
    $display("step branches checked");

    // STR R2,[R4] then stall
    after_pos();
    bus.status      = 4'b0000;
    bus.instruction = 32'hE584_2000;
    #1;
    check("str_mem_w",   32'(bus.mem_w_en), 32'd1);
    check("str_src2",    32'(bus.src2), 32'd2);
    check("str_two_src", 32'(bus.two_src), 32'd1);
    check("str_rm",      bus.value_rm, 32'd2);
    check("str_rn",      bus.value_rn, 32'd4);
    check("str_wb_en",   32'(bus.wb_en), 32'd0);
    bus.hazard = 1'b1;
    #1;
    check("str_hz_mem_w", 32'(bus.mem_w_en), 32'd0);
    check("str_hz_src2",  32'(bus.src2), 32'd2);
    bus.hazard = 1'b0;
    // LDR R2,[R4]
    bus.instruction = 32'hE594_2000;
    #1;
    check("ldr_mem_r", 32'(bus.mem_r_en), 32'd1);
    check("ldr_wb_en", 32'(bus.wb_en), 32'd1);
    check("ldr_mem_w", 32'(bus.mem_w_en), 32'd0);
    check("ldr_src2",  32'(bus.src2), 32'd0);
    $display("step STR/LDR checked");

    // MOVS R0,#5 then CMP R0,R1
    after_pos();
    bus.instruction = 32'hE3B0_0005;
    #1;
    check("movs_exe_cmd", 32'(bus.exe_cmd), 32'h1);
    check("movs_s",       32'(bus.s), 32'd1);
    check("movs_imm",     32'(bus.imm), 32'd1);
    check("movs_two_src", 32'(bus.two_src), 32'd0);
    check("movs_shop",    32'(bus.shift_operand), 32'h005);
    bus.instruction = 32'hE150_0001;
    #1;
    check("cmp_wb_en",   32'(bus.wb_en), 32'd0);
    check("cmp_exe_cmd", 32'(bus.exe_cmd), 32'h4);
    check("cmp_s",       32'(bus.s), 32'd1);
    $display("step MOVS/CMP checked");

    // Mid-cycle reset after R3 <= 0x55
    after_pos();
    bus.instruction = 32'hE082_1003;
    bus.wb_wb_en    = 1'b1;
    bus.wb_dest     = 4'd3;
    bus.wb_value    = 32'h55;
    after_neg();
    check("r3_written", bus.value_rm, 32'h55);
    #1 rst = 1'b1;
    #1;
    check("r3_rst_now", bus.value_rm, 32'd3);
    after_neg();
    check("r3_rst_drop", bus.value_rm, 32'd3);
    bus.wb_wb_en = 1'b0;
    rst = 1'b0;
    #1;
    check("r3_after_rel", bus.value_rm, 32'd3);
    $display("step mid-cycle reset checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
